// File: rtl/lfsr_pkg.sv
// Shared constants and the single-step Galois update for the parametrised LFSR.
package lfsr_pkg;

  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  localparam int unsigned LFSR_WIDTH_MIN = 3;
  localparam int unsigned LFSR_WIDTH_MAX = 64;
  localparam int unsigned LFSR_STEPS_MIN = 1;
  localparam int unsigned LFSR_STEPS_MAX = 8;

  // Operands are zero-extended to 64 bits, so narrower registers step correctly after truncation.
  function automatic logic [63:0] lfsr_step(input logic [63:0] state, input logic [63:0] taps);
    return (state >> 1) ^ (state[0] ? taps : 64'd0);
  endfunction

endpackage

// File: rtl/lfsr_step_unroll.sv
// Combinational chain of STEPS Galois shifts, flagging whether any produced state equals SEED.
module lfsr_step_unroll
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_32),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int unsigned      STEPS = 1
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_state,
  output logic             o_seed_hit
);

  logic [WIDTH-1:0] w_chain [STEPS+1];
  logic [STEPS-1:0] w_hit;

  assign w_chain[0] = i_state;

  for (genvar i = 0; i < STEPS; i++) begin : g_stage
    assign w_chain[i+1] = WIDTH'(lfsr_step(64'(w_chain[i]), 64'(TAPS)));
    assign w_hit[i]     = (w_chain[i+1] == SEED);
  end

  assign o_state    = w_chain[STEPS];
  assign o_seed_hit = |w_hit;

endmodule

// File: rtl/lfsr_galois_param.sv
// Parametrised Galois LFSR with clock enable, zero-safe runtime seed load and period-wrap pulse.
module lfsr_galois_param
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_32),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int unsigned      STEPS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             load_err
);

  if (WIDTH < LFSR_WIDTH_MIN || WIDTH > LFSR_WIDTH_MAX) begin : g_bad_width
    $error("lfsr_galois_param: WIDTH out of range");
  end
  if (STEPS < LFSR_STEPS_MIN || STEPS > LFSR_STEPS_MAX) begin : g_bad_steps
    $error("lfsr_galois_param: STEPS out of range");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
    $error("lfsr_galois_param: TAPS MSB must be set");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_galois_param: SEED must be nonzero");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_load_err;

  logic [WIDTH-1:0] w_step_q;
  logic             w_seed_hit;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;
  logic             w_load_err_next;

  lfsr_step_unroll #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED),
    .STEPS (STEPS)
  ) u_step (
    .i_state    (r_q),
    .o_state    (w_step_q),
    .o_seed_hit (w_seed_hit)
  );

  // Load outranks enable; a zero seed falls back to SEED so lockup is unreachable.
  always_comb begin
    w_q_next        = r_q;
    w_wrap_next     = 1'b0;
    w_load_err_next = 1'b0;
    if (load) begin
      if (seed_in != '0) begin
        w_q_next = seed_in;
      end else begin
        w_q_next        = SEED;
        w_load_err_next = 1'b1;
      end
    end else if (en) begin
      w_q_next    = w_step_q;
      w_wrap_next = w_seed_hit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q        <= SEED;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_q        <= w_q_next;
      r_wrap     <= w_wrap_next;
      r_load_err <= w_load_err_next;
    end
  end

  assign q        = r_q;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: doc/lfsr_galois_param.md
Name: lfsr_galois_param

Overview:
Parametrised Galois LFSR, the successor to the fixed 32-bit pseudo-random generator, for stimulus and scrambler sequences. It generalises width, tap mask, seed and steps-per-clock. It adds a clock enable, a runtime seed load with zero-state lockup protection, and a period-wrap indicator. It sits beside bench and datapath blocks as a configurable PRBS source.

Parameters:
WIDTH, 32, register width; legal range 3..64.
TAPS, 32'h8020_0003, Galois feedback mask (WIDTH bits); bit i set means q[0] is XORed into next[i]. Bit WIDTH-1 must be 1; enforced by an elaboration-time check.
SEED, 1, reset and recovery value; must be nonzero (elaboration check).
STEPS, 1, LFSR shifts applied per enabled clock; legal range 1..8.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  advance the LFSR by STEPS shifts this cycle
load  input  1  load seed_in this cycle; takes priority over en
seed_in  input  WIDTH  runtime seed value
q  output  WIDTH  current LFSR state (registered)
wrap  output  1  registered pulse: the sequence passed through SEED during the last advance
load_err  output  1  registered pulse: a zero seed was rejected

Behaviour:
- Single-step function: next = (q >> 1) XOR (q[0] ? TAPS : 0).
  - With the defaults this gives next[31] = q[0], next[21] = q[22]^q[0], next[1] = q[2]^q[0], next[0] = q[1]^q[0].
- reset asserted (asynchronous, at any time, including mid-sequence or during load): q = SEED, wrap = 0, load_err = 0 immediately. The first update happens on the first rising edge after reset deasserts.
- Per rising edge, in priority order:
  1. load=1, seed_in != 0: q <= seed_in; wrap <= 0; load_err <= 0. en is ignored.
  2. load=1, seed_in == 0: q <= SEED; load_err <= 1; wrap <= 0. The all-zero lockup state can never be entered.
  3. load=0, en=1: q <= step applied STEPS times to q. wrap <= 1 if any of the STEPS intermediate or final states equals SEED, else 0. load_err <= 0.
  4. otherwise: q holds; wrap <= 0; load_err <= 0.
- Latency: q reflects the action taken at edge N immediately after edge N. wrap and load_err are one-cycle pulses aligned with that updated q.
- Combinational depth: STEPS cascaded step stages. There is no internal pipelining, so latency is 1 cycle for every STEPS value.
- q is never 0 after reset, for any legal TAPS, because a nonzero state maps to a nonzero state. The bench asserts this.
- The wrap comparison is per-step against the SEED parameter, not against a loaded seed_in.

Decomposition:
- Package lfsr_pkg holds:
  - the default tap constant, LFSR_TAPS_32 = 32'h8020_0003;
  - a parametrised step function (state, taps) returning the next state;
  - the legal-range constants for WIDTH and STEPS.
- One sub-module, lfsr_step_unroll: purely combinational, parameters WIDTH/TAPS/STEPS/SEED. It outputs the final state and the any-equals-SEED flag.
- The top block holds the registers, the load/en priority and the async reset.

Test Plan:
- Defaults, reset then en=1 for 3 cycles -> q = 0x80200003, 0xC0300002, 0x60180001; wrap = 0 throughout.
- Defaults with STEPS=2, one en cycle after reset -> q = 0xC0300002 directly.
- WIDTH=4, TAPS=4'b1001, SEED=1, en held high -> q sequence 9,13,15,14,7,10,5,11,12,6,3,8,4,2,1. wrap pulses only on the 15th cycle, then every 15 cycles; q is never 0.
- load=1 with seed_in=0 (defaults) -> next q = 0x00000001, load_err = 1 for exactly one cycle. load=1 with seed_in=0xDEADBEEF and en=1 in the same cycle -> q = 0xDEADBEEF, no step applied.
- en toggled 1,0,0,1 -> q holds across the en=0 cycles and advances only on en=1 edges; wrap stays 0 while idle.
- Mid-run reset asserted between clock edges -> q = SEED and wrap/load_err = 0 before the next edge. Compare against a step-function reference model over 200k random en/load/seed cycles: zero mismatches.
